servisia_mem_seq: RTL and testbench

- Upstream sequencer for the byte-wide flash/SRAM memory stage.
- Accepts 32-bit Wishbone-classic word requests from the SERV core bus and serialises each into 4 one-byte accesses on the 8-bit memory port.
- On reads, collects the registered byte returns into a word.
- Pulses a single-cycle ack when the word is complete.

---
 rtl/servisia_pkg.sv | 15 +
 rtl/servisia_byte_gather.sv | 30 +++
 rtl/servisia_mem_seq.sv | 144 ++++++++++++++
 tb/tb_servisia_mem_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/servisia_pkg.sv
// Shared types and defaults for the byte-serial memory sequencer.
package servisia_pkg;

  localparam int unsigned SERVISIA_ADDR_W = 20;
  localparam int unsigned SERVISIA_BYTES  = 4;
  localparam int unsigned LANE_W          = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDrain,
    StAck
  } seq_state_e;

endpackage

// File: rtl/servisia_byte_gather.sv
// Right-shifting byte collector: each capture pushes a byte in at the top,
// so after BYTES captures the first byte sits in the low lane.
module servisia_byte_gather
  import servisia_pkg::*;
#(
  parameter int unsigned BYTES = SERVISIA_BYTES
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      en_i,
  input  logic [LANE_W-1:0]         byte_i,
  output logic [LANE_W*BYTES-1:0]   word_o
);

  localparam int unsigned WORD_W = LANE_W * BYTES;

  logic [WORD_W-1:0] r_shreg;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_shreg <= '0;
    end else if (en_i) begin
      r_shreg <= {byte_i, r_shreg[WORD_W-1:LANE_W]};
    end
  end

  assign word_o = r_shreg;

endmodule

// File: rtl/servisia_mem_seq.sv
// Serialises Wishbone word requests into BYTES one-byte memory accesses and
// reassembles read bytes into a word, acking once per request.
module servisia_mem_seq
  import servisia_pkg::*;
#(
  parameter int unsigned ADDR_W = SERVISIA_ADDR_W,
  parameter int unsigned BYTES  = SERVISIA_BYTES
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               wb_adr_i,
  input  logic [LANE_W*BYTES-1:0]   wb_dat_i,
  input  logic [BYTES-1:0]          wb_sel_i,
  input  logic                      wb_we_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  output logic                      wb_ack_o,
  output logic [LANE_W*BYTES-1:0]   wb_rdt_o,
  output logic                      mem_read_o,
  output logic                      mem_write_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [LANE_W-1:0]         mem_wdata_o,
  input  logic [LANE_W-1:0]         mem_rdata_i,
  output logic                      busy_o
);

  localparam int unsigned WORD_W = LANE_W * BYTES;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam logic [OFF_W-1:0] K_LAST = OFF_W'(BYTES - 1);
  localparam logic [OFF_W-1:0] K_ONE  = OFF_W'(1);

  seq_state_e              r_state, w_state_d;
  logic [OFF_W-1:0]        r_k, w_k_d, w_k_nxt;
  logic                    r_we;
  logic [BYTES-1:0]        r_sel;
  logic [WORD_W-1:0]       r_dat;
  logic [ADDR_W-OFF_W-1:0] r_wadr;

  logic                    r_mem_read, w_mem_read_d;
  logic                    r_mem_write, w_mem_write_d;
  logic [ADDR_W-1:0]       r_mem_addr, w_mem_addr_d;
  logic [LANE_W-1:0]       r_mem_wdata, w_mem_wdata_d;

  logic                    w_accept, w_capture;
  logic [WORD_W-1:0]       w_word;

  assign w_accept = (r_state == StIdle) && wb_cyc_i && wb_stb_i;
  assign w_k_nxt  = r_k + K_ONE;

  always_comb begin
    w_state_d     = r_state;
    w_k_d         = r_k;
    w_capture     = 1'b0;
    w_mem_read_d  = 1'b0;
    w_mem_write_d = 1'b0;
    w_mem_addr_d  = '0;
    w_mem_wdata_d = '0;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          // Byte 0 is issued straight from the bus on the accept edge.
          w_state_d     = StAccess;
          w_k_d         = '0;
          w_mem_read_d  = !wb_we_i;
          w_mem_write_d = wb_we_i && wb_sel_i[0];
          w_mem_addr_d  = {wb_adr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          w_mem_wdata_d = wb_dat_i[LANE_W-1:0];
        end
      end
      StAccess: begin
        w_capture = !r_we && (r_k != '0);
        if (r_k == K_LAST) begin
          w_state_d = r_we ? StAck : StDrain;
        end else begin
          w_k_d         = w_k_nxt;
          w_mem_read_d  = !r_we;
          w_mem_write_d = r_we && r_sel[w_k_nxt];
          w_mem_addr_d  = {r_wadr, w_k_nxt};
          w_mem_wdata_d = r_dat[{w_k_nxt, 3'b000} +: LANE_W];
        end
      end
      StDrain: begin
        w_capture = 1'b1;
        w_state_d = StAck;
      end
      StAck: begin
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_k         <= '0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_dat       <= '0;
      r_wadr      <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_d;
      r_k         <= w_k_d;
      r_mem_read  <= w_mem_read_d;
      r_mem_write <= w_mem_write_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      if (w_accept) begin
        r_we   <= wb_we_i;
        r_sel  <= wb_sel_i;
        r_dat  <= wb_dat_i;
        r_wadr <= wb_adr_i[ADDR_W-1:OFF_W];
      end
    end
  end

  servisia_byte_gather #(
    .BYTES (BYTES)
  ) u_gather (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (w_accept),
    .en_i   (w_capture),
    .byte_i (mem_rdata_i),
    .word_o (w_word)
  );

  assign wb_ack_o    = (r_state == StAck);
  assign wb_rdt_o    = (wb_ack_o && !r_we) ? w_word : '0;
  assign busy_o      = (r_state != StIdle);
  assign mem_read_o  = r_mem_read;
  assign mem_write_o = r_mem_write;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

  // Lane 0 is always issued from the live bus, never from the latched copy.
  logic w_unused;
  assign w_unused = ^{wb_adr_i[31:ADDR_W], wb_adr_i[OFF_W-1:0], r_sel[0], r_dat[LANE_W-1:0]};

endmodule

// File: tb/tb_servisia_mem_seq.sv
// Directed bench for servisia_mem_seq with a registered byte-memory model.
module tb_servisia_mem_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic        wb_ack;
  logic [31:0] wb_rdt;
  logic        mem_read, mem_write;
  logic [19:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_acks   = 0;
  logic        mon_en   = 1'b0;
  logic        prev_ack = 1'b0;
  logic [7:0]  mem_model [int unsigned];

  always #5 clk = ~clk;

  servisia_mem_seq dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wb_adr_i    (wb_adr),
    .wb_dat_i    (wb_dat),
    .wb_sel_i    (wb_sel),
    .wb_we_i     (wb_we),
    .wb_cyc_i    (wb_cyc),
    .wb_stb_i    (wb_stb),
    .wb_ack_o    (wb_ack),
    .wb_rdt_o    (wb_rdt),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy)
  );

  // Byte presented with mem_read in cycle N comes back in cycle N+1.
  always @(posedge clk) begin
    if (mem_read) begin
      mem_rdata <= mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : 8'h00;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("rw_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
      check("ack_single", {31'd0, wb_ack & prev_ack}, 32'd0);
      if (wb_ack) n_acks++;
    end
    prev_ack <= wb_ack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and checks every cycle up to and including the ack.
  task automatic do_req(input string tag, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input logic [31:0] exp_rdt, input logic [19:0] exp_base,
                        input bit hold);
    int lat;
    lat    = we ? 5 : 6;
    wb_we  = we;
    wb_adr = adr;
    wb_dat = dat;
    wb_sel = sel;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      tick();
      if (c <= 4) begin
        check({tag, "_rd"}, {31'd0, mem_read}, {31'd0, !we});
        check({tag, "_wr"}, {31'd0, mem_write}, {31'd0, we & sel[c-1]});
        check({tag, "_addr"}, {12'd0, mem_addr}, {12'd0, exp_base + 20'(c - 1)});
        if (we && sel[c-1]) check({tag, "_wdata"}, {24'd0, mem_wdata}, {24'd0, dat[8*(c-1) +: 8]});
      end else begin
        check({tag, "_strobes_off"}, {30'd0, mem_read, mem_write}, 32'd0);
      end
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (c == lat) begin
        check({tag, "_ack"}, {31'd0, wb_ack}, 32'd1);
        check({tag, "_rdt"}, wb_rdt, exp_rdt);
      end else begin
        check({tag, "_noack"}, {31'd0, wb_ack}, 32'd0);
      end
    end
    if (!hold) begin
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_ack"}, {31'd0, wb_ack}, 32'd0);
    check({tag, "_rdt"}, wb_rdt, 32'd0);
    check({tag, "_strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
  endtask

  initial begin
    int unsigned acks_before;
    mem_model[32'h00010] = 8'h11;
    mem_model[32'h00011] = 8'h22;
    mem_model[32'h00012] = 8'h33;
    mem_model[32'h00013] = 8'h44;
    mem_model[32'h00020] = 8'hDE;
    mem_model[32'h00021] = 8'hAD;
    mem_model[32'h00022] = 8'hBE;
    mem_model[32'h00023] = 8'hEF;
    mem_model[32'hFFFFC] = 8'hC1;
    mem_model[32'hFFFFD] = 8'hC2;
    mem_model[32'hFFFFE] = 8'hC3;
    mem_model[32'hFFFFF] = 8'hC4;

    rst = 1'b1; wb_adr = '0; wb_dat = '0; wb_sel = '0;
    wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    check_idle("reset");
    check("reset_addr", {12'd0, mem_addr}, 32'd0);

    // Only one of cyc/stb high: ignored.
    wb_cyc = 1'b1;
    tick();
    check("cyc_only_busy", {31'd0, busy}, 32'd0);
    wb_cyc = 1'b0; wb_stb = 1'b1;
    tick();
    check("stb_only_busy", {31'd0, busy}, 32'd0);
    wb_stb = 1'b0;

    do_req("read", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h4433_2211, 20'h00010, 1'b0);
    tick();
    check_idle("read_after");

    // Bit 19 set selects SRAM; lane k carries dat[8k+7:8k].
    do_req("write", 1'b1, 32'h0008_0004, 32'hA5B6_C7D8, 4'b1010, 32'h0, 20'h80004, 1'b0);
    tick();
    check_idle("write_after");

    // Back-to-back with cyc/stb held through the ack cycle.
    acks_before = n_acks;
    do_req("b2b_a", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h4433_2211, 20'h00010, 1'b1);
    wb_adr = 32'h0000_0020;
    tick();
    check_idle("b2b_gap");
    do_req("b2b_b", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'hEFBE_ADDE, 20'h00020, 1'b0);
    tick();
    check_idle("b2b_after");
    check("b2b_acks", n_acks - acks_before, 32'd2);

    // Reset in the middle of a read while byte 2 is presented.
    wb_we = 1'b0; wb_adr = 32'h0000_0010; wb_cyc = 1'b1; wb_stb = 1'b1;
    tick();
    tick();
    tick();
    check("rst_mid_addr", {12'd0, mem_addr}, 32'h00012);
    rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0;
    tick();
    rst = 1'b0;
    check_idle("rst_mid");
    check("rst_mid_addr0", {12'd0, mem_addr}, 32'd0);
    tick();
    check_idle("rst_mid2");
    do_req("post_rst", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'hEFBE_ADDE, 20'h00020, 1'b0);
    tick();

    // Top of address space: upper bus bits ignored, no wrap into 0x00000.
    do_req("top", 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'hC4C3_C2C1, 20'hFFFFC, 1'b0);
    tick();
    check_idle("top_after");

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
